rdft_frame_sequencer: RTL and testbench

Frame sequencer and twiddle scheduler for one complex recursive‑DFT bin datapath. It accepts complex samples over a valid/ready handshake and forwards them to the datapath one per cycle. It counts N samples per frame, then waits out the datapath latency, captures the bin result and pulses the datapath clear. It also advances the complex twiddle (tw_cos, tw_sin) by one fixed rotation step per frame, replacing the free‑running `repeat`/`#1` reset scheme with a synthesizable controller.

---
 rtl/rdft_frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_rdft_frame_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rdft_frame_sequencer.sv
// rdft_frame_sequencer: frame controller and twiddle scheduler for a recursive-DFT bin datapath.
// Optional RDFT_TW_RESYNC_EN: reload the twiddle to exact unity whenever frame_cnt wraps, cancelling drift.
module rdft_frame_sequencer #(
    parameter int W        = 32,
    parameter int N        = 53,
    parameter int FRAC     = 20,
    parameter int LAT      = 3,
    parameter int COS_STEP = 1041216,
    parameter int SIN_STEP = 124019,
    parameter int NBINS    = 53
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_data,
    input  logic [W-1:0]               in_data_j,
    output logic                       dp_clr,
    output logic                       dp_en,
    output logic [W-1:0]               dp_in,
    output logic [W-1:0]               dp_in_j,
    input  logic [W-1:0]               dp_out,
    input  logic [W-1:0]               dp_out_j,
    output logic [W-1:0]               tw_cos,
    output logic [W-1:0]               tw_sin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [W-1:0]               out_data_j,
    output logic [$clog2(NBINS)-1:0]   frame_cnt,
    output logic                       busy
);
    localparam int CMAX = (N > LAT + 1) ? N : LAT + 1;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int FW   = $clog2(NBINS);
    localparam int W2   = 2 * W;
    localparam logic signed [W-1:0] L_COS = W'(COS_STEP);
    localparam logic signed [W-1:0] L_SIN = W'(SIN_STEP);
    localparam logic signed [W-1:0] L_ONE = W'(1) << FRAC;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_HOLD, S_ROTATE} state_t;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic                  r_dp_en;
    logic [W-1:0]          r_dp_in, r_dp_in_j, r_out_data, r_out_data_j;
    logic signed [W-1:0]   r_tw_cos, r_tw_sin;
    logic [FW-1:0]         r_frame_cnt;
    logic                  w_accept, w_last, w_capture, w_wrap;
    logic signed [W2-1:0]  w_re, w_im;
    logic signed [W-1:0]   w_cos_n, w_sin_n;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = w_accept && r_cnt == CW'(N - 1);
    assign w_capture = r_state == S_FLUSH && r_cnt == CW'(LAT);
    assign w_wrap    = r_frame_cnt == FW'(NBINS - 1);

    // Rotation uses pre-update values; floor shift then wrap to W bits
    assign w_re = W2'(r_tw_cos) * W2'(L_COS) - W2'(r_tw_sin) * W2'(L_SIN);
    assign w_im = W2'(r_tw_sin) * W2'(L_COS) + W2'(r_tw_cos) * W2'(L_SIN);
`ifdef RDFT_TW_RESYNC_EN
    assign w_cos_n = w_wrap ? L_ONE : W'(w_re >>> FRAC);
    assign w_sin_n = w_wrap ? '0 : W'(w_im >>> FRAC);
`else
    assign w_cos_n = W'(w_re >>> FRAC);
    assign w_sin_n = W'(w_im >>> FRAC);
`endif

    assign dp_en      = r_dp_en;
    assign dp_in      = r_dp_in;
    assign dp_in_j    = r_dp_in_j;
    assign tw_cos     = r_tw_cos;
    assign tw_sin     = r_tw_sin;
    assign out_valid  = r_state == S_HOLD;
    assign out_data   = r_out_data;
    assign out_data_j = r_out_data_j;
    assign frame_cnt  = r_frame_cnt;
    assign busy       = r_state != S_IDLE;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake/clear strobes
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        dp_clr   = 1'b0;
        case (r_state)
            S_IDLE:   w_next = run ? S_CLEAR : S_IDLE;
            S_CLEAR:  begin dp_clr = 1'b1; w_next = S_RUN; end
            S_RUN:    begin in_ready = 1'b1; w_next = w_last ? S_FLUSH : S_RUN; end
            S_FLUSH:  w_next = w_capture ? S_HOLD : S_FLUSH;
            S_HOLD:   w_next = out_ready ? S_ROTATE : S_HOLD;
            S_ROTATE: w_next = run ? S_CLEAR : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Shared counter: accepted samples in RUN, then cycles since the final dp_en in FLUSH
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              r_cnt <= '0;
        else if (r_state == S_CLEAR || w_last) r_cnt <= '0;
        else if (w_accept || r_state == S_FLUSH) r_cnt <= r_cnt + 1'b1;
    end

    // Sample register toward the datapath and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_en      <= 1'b0;
            r_dp_in      <= '0;
            r_dp_in_j    <= '0;
            r_out_data   <= '0;
            r_out_data_j <= '0;
        end else begin
            r_dp_en <= w_accept;
            if (w_accept) begin
                r_dp_in   <= in_data;
                r_dp_in_j <= in_data_j;
            end
            if (w_capture) begin
                r_out_data   <= dp_out;
                r_out_data_j <= dp_out_j;
            end
        end
    end

    // Twiddle rotation and frame index advance once per frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tw_cos    <= L_ONE;
            r_tw_sin    <= '0;
            r_frame_cnt <= '0;
        end else if (r_state == S_ROTATE) begin
            r_tw_cos    <= w_cos_n;
            r_tw_sin    <= w_sin_n;
            r_frame_cnt <= w_wrap ? '0 : r_frame_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rdft_frame_sequencer.sv
// tb_rdft_frame_sequencer: scoreboard bench for rdft_frame_sequencer with a summing LAT=3 datapath model.
module tb_rdft_frame_sequencer;
    logic        clk = 1'b0;
    logic        rst, run, in_valid, in_ready, out_ready;
    logic [31:0] in_data, in_data_j;
    logic        dp_clr, dp_en, out_valid, busy;
    logic [31:0] dp_in, dp_in_j, dp_out, dp_out_j, tw_cos, tw_sin, out_data, out_data_j;
    logic [1:0]  frame_cnt;

    typedef struct {
        logic [31:0] r, j, c, s;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          e_fc = 0;
    logic [31:0] e_c[4] = '{32'd1048576, 32'd0, -32'sd1048576, 32'd0};
    logic [31:0] e_s[4] = '{32'd0, 32'd1048576, 32'd0, -32'sd1048576};

    always #5 clk = ~clk;

    rdft_frame_sequencer #(
        .W(32), .N(4), .FRAC(20), .LAT(3), .COS_STEP(0), .SIN_STEP(1048576), .NBINS(4)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_data_j(in_data_j), .dp_clr(dp_clr), .dp_en(dp_en),
        .dp_in(dp_in), .dp_in_j(dp_in_j), .dp_out(dp_out), .dp_out_j(dp_out_j),
        .tw_cos(tw_cos), .tw_sin(tw_sin), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_data_j(out_data_j), .frame_cnt(frame_cnt), .busy(busy)
    );

    // Datapath model: accumulate the frame, result visible LAT cycles after the last dp_en
    logic [31:0] acc, acc_j, p0, p0_j, p1, p1_j;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 0; acc_j <= 0; p0 <= 0; p0_j <= 0; p1 <= 0; p1_j <= 0;
        end else begin
            if (dp_clr) begin acc <= 0; acc_j <= 0; end
            else if (dp_en) begin acc <= acc + dp_in; acc_j <= acc_j + dp_in_j; end
            p0 <= acc; p0_j <= acc_j; p1 <= p0; p1_j <= p0_j;
        end
    end
    assign dp_out   = p1;
    assign dp_out_j = p1_j;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Result monitor: pop the expected frame on every result handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("sb_has_entry", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", out_data, e.r);
                chk("out_data_j", out_data_j, e.j);
                chk("hold_tw_cos", tw_cos, e.c);
                chk("hold_tw_sin", tw_sin, e.s);
                chk("hold_frame_cnt", {30'd0, frame_cnt}, e.fc);
            end
        end
    end

    // Timing monitor: clear pulse width, clear/enable exclusion, enable count and result latency
    int cyc = 0, last_en = 0, n_en = 0;
    logic pv_clr = 1'b0, pv_ov = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (dp_en) begin last_en = cyc; n_en++; end
            if (pv_clr) chk("clr_one_cycle", {31'd0, dp_clr}, 32'd0);
            if (dp_clr) begin chk("clr_vs_en", {31'd0, dp_en}, 32'd0); n_en = 0; end
            if (out_valid && !pv_ov) begin
                chk("en_to_valid", cyc - last_en, 32'd4);
                chk("en_per_frame", n_en, 32'd4);
            end
        end
        pv_clr = dp_clr;
        pv_ov  = out_valid;
    end

    // Drive samples base+k until m accepts; handshake known from in_ready before the edge
    task automatic send(input int br, input int bj, input bit gap, input int m,
                        input logic [31:0] er, input logic [31:0] ej);
        int k = 0, guard = 0;
        bit on = 1'b1, acc_now;
        if (m == 4) begin
            sb.push_back('{r: er, j: ej, c: e_c[e_fc], s: e_s[e_fc], fc: e_fc});
            e_fc = (e_fc + 1) % 4;
        end
        @(posedge clk); #1;
        while (k < m && guard < 100) begin
            in_valid  = on;
            in_data   = on ? br + k : 32'hdead;
            in_data_j = on ? bj + k : 32'hbeef;
            acc_now   = on && in_ready;
            @(posedge clk); #1;
            if (acc_now) begin
                chk("dp_en_after_accept", {31'd0, dp_en}, 32'd1);
                chk("dp_in", dp_in, br + k);
                chk("dp_in_j", dp_in_j, bj + k);
                k++;
            end else chk("dp_en_idle", {31'd0, dp_en}, 32'd0);
            if (gap) on = !on;
            guard++;
        end
        chk("send_accepts", k, m);
        in_valid = 1'b0;
        if (m == 4) chk("in_ready_after_last", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
        chk("frame_timeout", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; in_valid = 1'b0; in_data = 0; in_data_j = 0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tw_cos", tw_cos, 32'd1048576);
        chk("rst_tw_sin", tw_sin, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_cnt", {30'd0, frame_cnt}, 32'd0);
        chk("rst_dp_clr", {31'd0, dp_clr}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0); in_data = 77;
            chk("idle_dp_en", {31'd0, dp_en}, 32'd0);
            chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;

        out_ready = 1'b1; run = 1'b1;
        send(1, 10, 1'b0, 4, 32'd10, 32'd46);
        wait_done();
        repeat (3) @(negedge clk);
        chk("f1_tw_cos", tw_cos, 32'd0);
        chk("f1_tw_sin", tw_sin, 32'd1048576);
        chk("f1_frame_cnt", {30'd0, frame_cnt}, 32'd1);

        out_ready = 1'b0;
        send(100, -50, 1'b0, 4, 32'd406, -32'sd194);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_stable", {31'd0, out_valid}, 32'd1);
            chk("bp_data_stable", out_data, 32'd406);
            chk("bp_data_j_stable", out_data_j, -32'sd194);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_tw_cos", tw_cos, 32'd0);
            chk("bp_tw_sin", tw_sin, 32'd1048576);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rot_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rot_tw_sin_pre", tw_sin, 32'd1048576);
        @(posedge clk); #1;
        chk("rot_tw_cos", tw_cos, -32'sd1048576);
        chk("rot_tw_sin", tw_sin, 32'd0);
        chk("rot_then_clr", {31'd0, dp_clr}, 32'd1);
        wait_done();

        send(7, 3, 1'b1, 4, 32'd34, 32'd18);
        wait_done();
        send(-20, 5, 1'b0, 4, -32'sd74, 32'd26);
        run = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("rev_tw_cos", tw_cos, 32'd1048576);
        chk("rev_tw_sin", tw_sin, 32'd0);
        chk("rev_frame_cnt", {30'd0, frame_cnt}, 32'd0);
        chk("rev_idle", {31'd0, busy}, 32'd0);

        run = 1'b1;
        send(1000, 0, 1'b0, 4, 32'd4006, 32'd6);
        wait_done();
        repeat (3) @(negedge clk);
        chk("f5_frame_cnt", {30'd0, frame_cnt}, 32'd1);
        send(50, 50, 1'b0, 2, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mrst_dp_en", {31'd0, dp_en}, 32'd0);
        chk("mrst_dp_in", dp_in, 32'd0);
        chk("mrst_dp_in_j", dp_in_j, 32'd0);
        chk("mrst_tw_cos", tw_cos, 32'd1048576);
        chk("mrst_tw_sin", tw_sin, 32'd0);
        chk("mrst_frame_cnt", {30'd0, frame_cnt}, 32'd0);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_out_data", out_data, 32'd0);
        e_fc = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("mrst_restart_clr", {31'd0, dp_clr}, 32'd1);
        send(2, -2, 1'b0, 4, 32'd14, -32'sd2);
        run = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("end_frame_cnt", {30'd0, frame_cnt}, 32'd1);
        chk("end_tw_sin", tw_sin, 32'd1048576);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
